// File: rtl/vga_text_scanner_if.sv
// Video RAM port b and font ROM read bus seen by the text scanner.
interface vga_text_scanner_if;
  logic [10:0] vram_addr;
  logic [31:0] vram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  modport master (output vram_addr, font_addr, input vram_data, font_data);
  modport slave  (input vram_addr, font_addr, output vram_data, font_data);
endinterface

// File: rtl/vga_text_scanner.sv
// Text-mode VGA scan-out: raster counters, cell/glyph fetch, 3-stage pixel pipe.
// Optional blinking cursor enabled by defining VGA_CURSOR_EN.
module vga_text_scanner #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int COLS      = 80,
  parameter int ROWS      = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_text_scanner_if.master    mem,
  input  logic [10:0]           cursor_pos,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int STAGES = 1;
  localparam logic [9:0]  H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  TEXT_W   = 10'(COLS * 8);
  localparam logic [9:0]  TEXT_H   = 10'(ROWS * 16);
  localparam logic [9:0]  HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]        h, v, h_d1, v_d1, h_d2, v_d2;
  logic [7:0]        attr_d2;
  logic [STAGES:0]   vld_pipe;
  logic              in_text, text_d2, pix_bit, v_wrap;
  logic [10:0]       cell_addr;
  logic [11:0]       colour;

  function automatic logic [11:0] pal(input logic [3:0] idx);
    logic [3:0] on, off;
    on  = idx[3] ? 4'hF : 4'hA;
    off = idx[3] ? 4'h5 : 4'h0;
    return {idx[2] ? on : off, idx[1] ? on : off, idx[0] ? on : off};
  endfunction

  assign in_text   = (h < TEXT_W) && (v < TEXT_H);
  assign cell_addr = 11'(v[9:4]) * 11'(COLS) + 11'(h[9:3]);
  assign v_wrap    = (h == H_LAST) && (v == V_LAST);

  assign mem.vram_addr = in_text ? cell_addr : '0;
  // Gate until the first real cell word has arrived so reset reads as 0.
  assign mem.font_addr = vld_pipe[0] ? {mem.vram_data[7:0], v_d1[3:0]} : '0;

`ifdef VGA_CURSOR_EN
  logic [4:0] frame_cnt;
  logic       cur_t0, cur_d1, cur_d2;
  logic       unused_bits;

  assign cur_t0 = frame_cnt[4] && in_text && (cell_addr == cursor_pos) &&
                  (cursor_pos < 11'(COLS * ROWS));
  assign pix_bit = mem.font_data[3'd7 - h_d2[2:0]] | (cur_d2 && (v_d2[3:1] == 3'b111));
  assign unused_bits = ^mem.vram_data[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      cur_d1    <= 1'b0;
      cur_d2    <= 1'b0;
    end else begin
      if (v_wrap) frame_cnt <= frame_cnt + 5'd1;
      cur_d1 <= cur_t0;
      cur_d2 <= cur_d1;
    end
  end
`else
  logic unused_bits;
  assign pix_bit     = mem.font_data[3'd7 - h_d2[2:0]];
  assign unused_bits = ^{mem.vram_data[31:16], cursor_pos};
`endif

  assign colour  = pix_bit ? pal(attr_d2[3:0]) : pal(attr_d2[7:4]);
  assign text_d2 = (h_d2 < TEXT_W) && (v_d2 < TEXT_H);

  always_ff @(posedge clk) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      vld_pipe    <= '0;
      h_d1        <= '0;
      v_d1        <= '0;
      h_d2        <= '0;
      v_d2        <= '0;
      attr_d2     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      h_d1     <= h;
      v_d1     <= v;
      h_d2     <= h_d1;
      v_d2     <= v_d1;
      attr_d2  <= mem.vram_data[15:8];
      // Output stage: blanking, sync and frame marker share the pixel's delay.
      {red, green, blue} <= (vld_pipe[1] && text_d2) ? colour : 12'h000;
      hsync       <= !(vld_pipe[1] && h_d2 >= HS_START && h_d2 < HS_END);
      vsync       <= !(vld_pipe[1] && v_d2 >= VS_START && v_d2 < VS_END);
      frame_start <= vld_pipe[1] && (h_d2 == 10'd0) && (v_d2 == 10'd0);
    end
  end

endmodule
